// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller with a double-buffered
// display word, blanking guard between digit slots and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  input  logic        load,
  input  logic        lz_en,
  output logic [3:0]  digit,
  output logic [7:0]  seg,
  output logic        frame_tick,
  output logic        upd_done
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);

  typedef enum logic {GUARD = 1'b0, SHOW = 1'b1} state_t;

  logic [CW-1:0] cnt_r, cnt_s;
  logic [1:0]    idx_r, idx_s;
  logic [15:0]   shadow_r, shadow_s, pend_r, pend_s;
  logic [3:0]    shadow_dp_r, shadow_dp_s, pend_dp_r, pend_dp_s;
  logic          flag_r, flag_s;
  logic          boundary_s;
  state_t        state_s;
  logic [3:0]    nib_s;
  logic [7:0]    dec_s;
  logic          blank_s;
  logic [3:0]    digit_s, digit_r;
  logic [7:0]    seg_s, seg_r;
  logic          tick_s, tick_r, upd_s, upd_r;

  function automatic logic [7:0] hex_decode(input logic [3:0] nib);
    logic [7:0] r;
    case (nib)
      4'h0:    r = 8'hC0;
      4'h1:    r = 8'hF9;
      4'h2:    r = 8'hA4;
      4'h3:    r = 8'hB0;
      4'h4:    r = 8'h99;
      4'h5:    r = 8'h92;
      4'h6:    r = 8'h82;
      4'h7:    r = 8'hF8;
      4'h8:    r = 8'h80;
      4'h9:    r = 8'h90;
      4'hA:    r = 8'h88;
      4'hB:    r = 8'h83;
      4'hC:    r = 8'hC6;
      4'hD:    r = 8'hA1;
      4'hE:    r = 8'h86;
      4'hF:    r = 8'h8E;
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  // A digit is a leading zero when it and every more significant nibble are zero.
  function automatic logic lead_zero(input logic [15:0] word, input logic [1:0] idx);
    logic r;
    case (idx)
      2'd3:    r = (word[15:12] == 4'h0);
      2'd2:    r = (word[15:8] == 8'h00);
      2'd1:    r = (word[15:4] == 12'h000);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Next slot position, buffer hand-over and the look-ahead output values.
  always_comb begin
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    shadow_s    = shadow_r;
    shadow_dp_s = shadow_dp_r;
    pend_s      = pend_r;
    pend_dp_s   = pend_dp_r;
    flag_s      = flag_r;
    digit_s     = 4'b0000;
    seg_s       = 8'hFF;
    nib_s       = 4'h0;
    dec_s       = 8'hFF;
    blank_s     = 1'b0;

    boundary_s = (cnt_r == LAST_CNT) && (idx_r == 2'd3);

    if (cnt_r == LAST_CNT) begin
      cnt_s = '0;
      idx_s = idx_r + 2'd1;
    end else begin
      cnt_s = cnt_r + CW'(1);
    end

    // A load landing on the boundary goes straight to the shadow register.
    if (boundary_s) begin
      if (load) begin
        shadow_s    = data;
        shadow_dp_s = dp;
        pend_s      = data;
        pend_dp_s   = dp;
      end else if (flag_r) begin
        shadow_s    = pend_r;
        shadow_dp_s = pend_dp_r;
      end else begin
        shadow_s    = shadow_r;
      end
      flag_s = 1'b0;
    end else if (load) begin
      pend_s    = data;
      pend_dp_s = dp;
      flag_s    = 1'b1;
    end else begin
      flag_s = flag_r;
    end

    state_s = (cnt_s < GUARD_END) ? GUARD : SHOW;

    nib_s   = shadow_s[{idx_s, 2'b00} +: 4];
    dec_s   = hex_decode(nib_s);
    blank_s = lz_en && lead_zero(shadow_s, idx_s);

    case (state_s)
      SHOW: begin
        digit_s = 4'b0001 << idx_s;
        seg_s   = {~shadow_dp_s[idx_s], (blank_s ? 7'h7F : dec_s[6:0])};
      end
      default: begin
        digit_s = 4'b0000;
        seg_s   = 8'hFF;
      end
    endcase

    tick_s = (cnt_s == LAST_CNT) && (idx_s == 2'd3);
    upd_s  = tick_s && flag_s;
  end

  // Scan position and display buffers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r       <= '0;
      idx_r       <= 2'd0;
      shadow_r    <= 16'h0000;
      shadow_dp_r <= 4'h0;
      pend_r      <= 16'h0000;
      pend_dp_r   <= 4'h0;
      flag_r      <= 1'b0;
    end else begin
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      shadow_r    <= shadow_s;
      shadow_dp_r <= shadow_dp_s;
      pend_r      <= pend_s;
      pend_dp_r   <= pend_dp_s;
      flag_r      <= flag_s;
    end
  end

  // Output registers, aligned with the slot position they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_r <= 4'b0000;
      seg_r   <= 8'hFF;
      tick_r  <= 1'b0;
      upd_r   <= 1'b0;
    end else begin
      digit_r <= digit_s;
      seg_r   <= seg_s;
      tick_r  <= tick_s;
      upd_r   <= upd_s;
    end
  end

  assign digit      = digit_r;
  assign seg        = seg_r;
  assign frame_tick = tick_r;
  // A load arriving during the boundary cycle is taken at that cycle's end, so
  // its acknowledge has to follow the strobe within the same cycle.
  assign upd_done   = upd_r | (tick_r & load);

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with SLOT_CYCLES=8, GUARD_CYCLES=2;
// position p counts cycles since reset release (p = frame*32 + digit*8 + cnt).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        load;
  logic        lz_en;
  logic [3:0]  digit;
  logic [7:0]  seg;
  logic        frame_tick;
  logic        upd_done;

  int n_checks = 0;
  int n_fail   = 0;
  int p        = 0;
  int ups      = 0;

  seg_scan_ctrl #(.SLOT_CYCLES(8), .GUARD_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp         (dp),
    .load       (load),
    .lz_en      (lz_en),
    .digit      (digit),
    .seg        (seg),
    .frame_tick (frame_tick),
    .upd_done   (upd_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    p++;
  endtask

  task automatic goto(input int t);
    while (p < t) step();
  endtask

  task automatic at_show(input string tag, input int t, input logic [3:0] d, input logic [7:0] s);
    goto(t);
    chk({tag, "_digit"}, 16'(digit), 16'(d));
    chk({tag, "_seg"}, 16'(seg), 16'(s));
  endtask

  task automatic at_flags(input string tag, input int t, input logic ft, input logic ud);
    goto(t);
    chk({tag, "_tick"}, 16'(frame_tick), 16'(ft));
    chk({tag, "_upd"}, 16'(upd_done), 16'(ud));
  endtask

  initial begin
    rst   = 1'b0;
    data  = 16'h0000;
    dp    = 4'h0;
    load  = 1'b0;
    lz_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_digit", 16'(digit), 16'h0000);
    chk("rst_seg", 16'(seg), 16'h00FF);
    chk("rst_tick", 16'(frame_tick), 16'h0000);
    chk("rst_upd", 16'(upd_done), 16'h0000);

    // idle scan after release
    rst = 1'b1;
    p   = 0;
    at_show("idle_g0", 0, 4'b0000, 8'hFF);
    at_show("idle_g1", 1, 4'b0000, 8'hFF);
    at_show("idle_s0", 2, 4'b0001, 8'hC0);
    at_show("idle_s0_end", 7, 4'b0001, 8'hC0);
    at_show("idle_g_d1", 8, 4'b0000, 8'hFF);
    at_show("idle_s1", 10, 4'b0010, 8'hC0);
    at_flags("idle_p30", 30, 1'b0, 1'b0);
    at_flags("idle_p31", 31, 1'b1, 1'b0);
    at_flags("idle_p32", 32, 1'b0, 1'b0);

    // mid-frame load only shows after the boundary
    goto(40);
    data = 16'h12AF;
    dp   = 4'b0100;
    load = 1'b1;
    step();
    load = 1'b0;
    data = 16'hFFFF;
    dp   = 4'hF;
    at_show("hold_d1", 42, 4'b0010, 8'hC0);
    at_show("hold_d3", 58, 4'b1000, 8'hC0);
    at_flags("ld_bnd", 63, 1'b1, 1'b1);
    at_flags("ld_after", 64, 1'b0, 1'b0);
    at_show("ld_d0", 66, 4'b0001, 8'h8E);
    at_show("ld_d1", 74, 4'b0010, 8'h88);
    at_show("ld_d2", 82, 4'b0100, 8'h24);
    at_show("ld_d3", 90, 4'b1000, 8'hF9);
    at_flags("ld_next_bnd", 95, 1'b1, 1'b0);

    // two loads in one frame: latest wins, one acknowledge
    goto(100);
    data = 16'h1111;
    dp   = 4'h0;
    load = 1'b1;
    step();
    data = 16'h2222;
    step();
    load = 1'b0;
    ups  = int'(upd_done);
    while (p < 126) begin
      step();
      ups += int'(upd_done);
    end
    chk("two_no_early_upd", 16'(ups), 16'h0000);
    at_flags("two_bnd", 127, 1'b1, 1'b1);
    at_show("two_d0", 130, 4'b0001, 8'hA4);
    at_show("two_d1", 138, 4'b0010, 8'hA4);
    at_show("two_d2", 146, 4'b0100, 8'hA4);
    at_show("two_d3", 154, 4'b1000, 8'hA4);
    at_flags("two_next_bnd", 159, 1'b1, 1'b0);

    // load coinciding with the boundary bypasses the pending register
    at_flags("byp_pre", 191, 1'b1, 1'b0);
    data = 16'h0007;
    dp   = 4'h0;
    load = 1'b1;
    #1;
    chk("byp_upd_same", 16'(upd_done), 16'h0001);
    step();
    load = 1'b0;
    chk("byp_upd_after", 16'(upd_done), 16'h0000);
    at_show("byp_d0", 194, 4'b0001, 8'hF8);
    at_show("byp_d1", 202, 4'b0010, 8'hC0);
    at_flags("byp_no_flag", 223, 1'b1, 1'b0);

    // leading-zero suppression
    goto(224);
    lz_en = 1'b1;
    data  = 16'h0040;
    load  = 1'b1;
    step();
    load  = 1'b0;
    at_show("lz40_d0", 258, 4'b0001, 8'hC0);
    at_show("lz40_d1", 266, 4'b0010, 8'h99);
    at_show("lz40_d2", 274, 4'b0100, 8'hFF);
    at_show("lz40_d3", 282, 4'b1000, 8'hFF);
    goto(288);
    data = 16'h0000;
    load = 1'b1;
    step();
    load = 1'b0;
    at_show("lz0_d0", 322, 4'b0001, 8'hC0);
    at_show("lz0_d1", 330, 4'b0010, 8'hFF);
    at_show("lz0_d2", 338, 4'b0100, 8'hFF);
    at_show("lz0_d3", 346, 4'b1000, 8'hFF);
    goto(352);
    dp   = 4'b1000;
    load = 1'b1;
    step();
    load = 1'b0;
    dp   = 4'h0;
    at_show("lz_dp_d3", 410, 4'b1000, 8'h7F);
    step();
    lz_en = 1'b0;

    // asynchronous reset in the middle of digit 2's show, with a load pending
    goto(420);
    data = 16'h5555;
    load = 1'b1;
    step();
    load = 1'b0;
    at_show("pre_rst_d2", 434, 4'b0100, 8'hC0);
    rst = 1'b0;
    #1;
    chk("arst_digit", 16'(digit), 16'h0000);
    chk("arst_seg", 16'(seg), 16'h00FF);
    chk("arst_tick", 16'(frame_tick), 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    p   = 0;
    at_show("rel_g0", 0, 4'b0000, 8'hFF);
    at_show("rel_d0", 2, 4'b0001, 8'hC0);
    at_show("rel_d1", 10, 4'b0010, 8'hC0);
    at_show("rel_d3", 26, 4'b1000, 8'hC0);
    at_flags("rel_bnd", 31, 1'b1, 1'b0);
    at_show("rel_next_d0", 34, 4'b0001, 8'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
